pipeline_ctrl: RTL and testbench

Central sequencer for the 5-stage pipelined CPU. It gates the PC and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and generates per-stage enables and synchronous flushes. It inserts load-use stall bubbles and squashes wrong-path instructions on taken branches and jumps resolved in MEM. A run/drain/halt state machine stops the core cleanly on a HALT opcode, and a set of performance counters is exposed for the testbench and external readout.

---
 rtl/cpu_ctrl_pkg.sv | 14 +
 rtl/hazard_detect.sv | 15 +
 rtl/pipeline_ctrl.sv | 154 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the CPU pipeline controller.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StHalted
    } ctrl_state_t;

    localparam logic [5:0]  OPC_HALT          = 6'b111111;
    localparam int unsigned DRAIN_CYCLES_DFLT = 3;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator: a load in EX whose destination feeds the instruction in ID.
module hazard_detect (
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       load_use
);

    // r0 is hardwired to zero, so a load targeting it never creates a dependency.
    always_comb begin
        load_use = ex_mem_read && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: stage enables/flushes, load-use stalls, redirect squash,
// run/drain/halt state machine and performance counters.
module pipeline_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter logic [5:0]  HALT_OPCODE  = OPC_HALT,
    parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DFLT,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             enable,
    input  logic [5:0]       id_opcode,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             mem_branch,
    input  logic             mem_zero_flag,
    input  logic             mem_jump,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned DrainW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    ctrl_state_t       state_q, state_d;
    logic [DrainW-1:0] drain_q, drain_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_q, flush_d;
    logic              redirect;
    logic              load_use;
    logic              halt_req;

    hazard_detect u_hazard_detect (
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .load_use    (load_use)
    );

    assign redirect = mem_jump | (mem_branch & mem_zero_flag);
    assign halt_req = (id_opcode == HALT_OPCODE);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= StIdle;
            drain_q <= '0;
            cycle_q <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            cycle_q <= cycle_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        cycle_d = cycle_q;
        stall_d = stall_q;
        flush_d = flush_q;
        unique case (state_q)
            StIdle: begin
                if (enable) state_d = StRun;
            end
            StRun: begin
                if (enable) begin
                    cycle_d = cycle_q + CNT_W'(1);
                    // A redirect squashes ID, so its stall or halt request is wrong-path.
                    if (redirect) begin
                        flush_d = flush_q + CNT_W'(1);
                    end else if (load_use) begin
                        stall_d = stall_q + CNT_W'(1);
                    end else if (halt_req) begin
                        drain_d = DrainW'(DRAIN_CYCLES);
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (enable) begin
                    cycle_d = cycle_q + CNT_W'(1);
                    if (redirect) flush_d = flush_q + CNT_W'(1);
                    drain_d = drain_q - DrainW'(1);
                    if (drain_q == DrainW'(1)) state_d = StHalted;
                end
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        running     = (state_q == StRun) || (state_q == StDrain);
        halted      = (state_q == StHalted);
        if (state_q == StRun && enable) begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            if (redirect) begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end else if (load_use || halt_req) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
        end else if (state_q == StDrain && enable) begin
            // Fetch is frozen; only the instructions already past ID retire.
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
            idex_flush  = 1'b1;
            ifid_flush  = redirect;
            exmem_flush = redirect;
        end
    end

    assign cycle_cnt = cycle_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl against a cycle-level behavioural model.
module tb_pipeline_ctrl;

    localparam int DrainCycles = 3;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        enable;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        mem_branch;
    logic        mem_zero_flag;
    logic        mem_jump;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush;
    logic        running, halted;
    logic [31:0] cycle_cnt, stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .enable        (enable),
        .id_opcode     (id_opcode),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .ex_mem_read   (ex_mem_read),
        .ex_rt         (ex_rt),
        .mem_branch    (mem_branch),
        .mem_zero_flag (mem_zero_flag),
        .mem_jump      (mem_jump),
        .pc_en         (pc_en),
        .ifid_en       (ifid_en),
        .idex_en       (idex_en),
        .exmem_en      (exmem_en),
        .memwb_en      (memwb_en),
        .ifid_flush    (ifid_flush),
        .idex_flush    (idex_flush),
        .exmem_flush   (exmem_flush),
        .running       (running),
        .halted        (halted),
        .cycle_cnt     (cycle_cnt),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: which phase the core is in, drain cycles left, and the three counters.
    bit          m_run, m_drain, m_halted;
    int          m_left;
    logic [31:0] m_cyc, m_stall, m_flush;
    logic [9:0]  e_ctl;
    logic [95:0] e_cnt;

    function automatic logic [9:0] obs_ctl();
        return {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_flush, exmem_flush, running, halted};
    endfunction

    function automatic logic [95:0] obs_cnt();
        return {cycle_cnt, stall_cnt, flush_cnt};
    endfunction

    function automatic logic [25:0] vec(input int en, input int opc, input int rs, input int rt,
                                        input int mr, input int ert, input int br, input int z,
                                        input int j);
        return {en[0], opc[5:0], rs[4:0], rt[4:0], mr[0], ert[4:0], br[0], z[0], j[0]};
    endfunction

    task automatic apply(input logic [25:0] v);
        {enable, id_opcode, id_rs, id_rt, ex_mem_read, ex_rt, mem_branch, mem_zero_flag,
         mem_jump} = v;
    endtask

    function automatic void model_reset();
        m_run = 0; m_drain = 0; m_halted = 0; m_left = 0;
        m_cyc = 0; m_stall = 0; m_flush = 0;
    endfunction

    function automatic void model_expect();
        logic       redir, lu, hlt;
        logic [9:0] c;
        redir = mem_jump | (mem_branch & mem_zero_flag);
        lu    = ex_mem_read && (ex_rt != 0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
        hlt   = (id_opcode == 6'h3F);
        c     = '0;
        if (m_run && enable) begin
            if (redir)           c = 10'b11111_111_00;
            else if (lu || hlt)  c = 10'b00111_010_00;
            else                 c = 10'b11111_000_00;
        end else if (m_drain && enable) begin
            c = {5'b00111, redir, 1'b1, redir, 2'b00};
        end
        c[1]  = m_run || m_drain;
        c[0]  = m_halted;
        e_ctl = c;
        e_cnt = {m_cyc, m_stall, m_flush};
    endfunction

    function automatic void model_advance();
        logic redir, lu, hlt;
        redir = mem_jump | (mem_branch & mem_zero_flag);
        lu    = ex_mem_read && (ex_rt != 0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
        hlt   = (id_opcode == 6'h3F);
        if (!enable || m_halted) return;
        if (!m_run && !m_drain) begin
            m_run = 1;
            return;
        end
        m_cyc++;
        if (redir) m_flush++;
        if (m_run) begin
            if (!redir && lu) m_stall++;
            else if (!redir && hlt) begin
                m_run = 0; m_drain = 1; m_left = DrainCycles;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_drain = 0; m_halted = 1;
            end
        end
    endfunction

    task automatic test_reset();
        apply('0);
        arst_n = 1'b0;
        model_reset();
        @(negedge clk);
        n_checks++;
        if (obs_ctl() !== 10'b0) begin
            n_fail++; $display("FAIL reset ctl: got %b want %b", obs_ctl(), 10'b0);
        end
        n_checks++;
        if (obs_cnt() !== 96'b0) begin
            n_fail++; $display("FAIL reset cnt: got %h want 0", obs_cnt());
        end
        arst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_start();
        logic [25:0] tbl[$];
        tbl.push_back(vec(0, 0, 1, 2, 0, 0, 0, 0, 0));
        repeat (7) tbl.push_back(vec(1, 0, 1, 2, 0, 0, 0, 0, 0));
        foreach (tbl[i]) begin
            apply(tbl[i]);
            @(negedge clk); model_expect();
            n_checks++;
            if (obs_ctl() !== e_ctl) begin
                n_fail++; $display("FAIL start ctl[%0d]: got %b want %b", i, obs_ctl(), e_ctl);
            end
            n_checks++;
            if (obs_cnt() !== e_cnt) begin
                n_fail++; $display("FAIL start cnt[%0d]: got %h want %h", i, obs_cnt(), e_cnt);
            end
            n_checks++;
            if (pc_en !== (i >= 2)) begin
                n_fail++; $display("FAIL start pc_en[%0d]: got %b want %b", i, pc_en, i >= 2);
            end
            if (i == 7) begin
                n_checks++;
                if (cycle_cnt !== 32'd5) begin
                    n_fail++; $display("FAIL start cycle_cnt: got %0d want 5", cycle_cnt);
                end
            end
            model_advance(); @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        logic [25:0] tbl[$];
        logic [31:0] s0;
        s0 = m_stall;
        tbl.push_back(vec(1, 0, 8, 3, 1, 8, 0, 0, 0));
        tbl.push_back(vec(1, 0, 8, 3, 0, 8, 0, 0, 0));
        tbl.push_back(vec(1, 0, 0, 4, 1, 0, 0, 0, 0));
        tbl.push_back(vec(1, 0, 1, 2, 0, 0, 0, 0, 0));
        foreach (tbl[i]) begin
            apply(tbl[i]);
            @(negedge clk); model_expect();
            n_checks++;
            if (obs_ctl() !== e_ctl) begin
                n_fail++; $display("FAIL loaduse ctl[%0d]: got %b want %b", i, obs_ctl(), e_ctl);
            end
            n_checks++;
            if ({pc_en, ifid_en, idex_flush} !== ((i == 0) ? 3'b001 : 3'b110)) begin
                n_fail++; $display("FAIL loaduse stall[%0d]: got %b", i,
                                   {pc_en, ifid_en, idex_flush});
            end
            if (i == 3) begin
                n_checks++;
                if (stall_cnt !== s0 + 32'd1) begin
                    n_fail++; $display("FAIL loaduse stall_cnt: got %0d want %0d", stall_cnt, s0 + 1);
                end
            end
            model_advance(); @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        logic [25:0] tbl[$];
        logic [31:0] f0;
        f0 = m_flush;
        tbl.push_back(vec(1, 0, 1, 2, 0, 0, 1, 1, 0));
        tbl.push_back(vec(1, 0, 1, 2, 0, 0, 1, 0, 0));
        tbl.push_back(vec(1, 0, 1, 2, 0, 0, 0, 0, 1));
        tbl.push_back(vec(1, 0, 1, 2, 0, 0, 0, 0, 0));
        foreach (tbl[i]) begin
            apply(tbl[i]);
            @(negedge clk); model_expect();
            n_checks++;
            if (obs_ctl() !== e_ctl) begin
                n_fail++; $display("FAIL branch ctl[%0d]: got %b want %b", i, obs_ctl(), e_ctl);
            end
            n_checks++;
            if ({pc_en, ifid_flush, idex_flush, exmem_flush} !==
                ((i == 0 || i == 2) ? 4'b1111 : 4'b1000)) begin
                n_fail++; $display("FAIL branch flush[%0d]: got %b", i,
                                   {pc_en, ifid_flush, idex_flush, exmem_flush});
            end
            if (i == 3) begin
                n_checks++;
                if (flush_cnt !== f0 + 32'd2) begin
                    n_fail++; $display("FAIL branch flush_cnt: got %0d want %0d", flush_cnt, f0 + 2);
                end
            end
            model_advance(); @(posedge clk); #1;
        end
    endtask

    task automatic test_simultaneous();
        logic [25:0] tbl[$];
        logic [31:0] s0;
        s0 = m_stall;
        tbl.push_back(vec(1, 63, 8, 3, 1, 8, 1, 1, 0));
        tbl.push_back(vec(1, 0, 1, 2, 0, 0, 0, 0, 0));
        foreach (tbl[i]) begin
            apply(tbl[i]);
            @(negedge clk); model_expect();
            n_checks++;
            if (obs_ctl() !== e_ctl) begin
                n_fail++; $display("FAIL simul ctl[%0d]: got %b want %b", i, obs_ctl(), e_ctl);
            end
            if (i == 1) begin
                n_checks++;
                if ({stall_cnt, pc_en, running, halted} !== {s0, 3'b110}) begin
                    n_fail++; $display("FAIL simul after: stall %0d pc_en %b running %b want %0d 1 1",
                                       stall_cnt, pc_en, running, s0);
                end
            end
            model_advance(); @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            int en, br, z, j, opc;
            en  = ($urandom_range(0, 9) != 0);
            j   = ($urandom_range(0, 9) == 0);
            br  = ($urandom_range(0, 4) == 0);
            z   = $urandom_range(0, 1);
            opc = $urandom_range(0, 62);
            if ((j != 0 || (br != 0 && z != 0)) && $urandom_range(0, 2) == 0) opc = 63;
            apply(vec(en, opc, $urandom_range(0, 3), $urandom_range(0, 3),
                      ($urandom_range(0, 2) == 0), $urandom_range(0, 3), br, z, j));
            @(negedge clk); model_expect();
            n_checks++;
            if (obs_ctl() !== e_ctl) begin
                n_fail++; $display("FAIL random ctl[%0d]: got %b want %b", i, obs_ctl(), e_ctl);
            end
            n_checks++;
            if (obs_cnt() !== e_cnt) begin
                n_fail++; $display("FAIL random cnt[%0d]: got %h want %h", i, obs_cnt(), e_cnt);
            end
            model_advance(); @(posedge clk); #1;
        end
    endtask

    task automatic test_halt();
        logic [25:0] tbl[$];
        tbl.push_back(vec(1, 63, 1, 2, 0, 0, 0, 0, 0));
        repeat (4) tbl.push_back(vec(1, 0, 1, 2, 0, 0, 0, 0, 0));
        tbl.push_back(vec(0, 0, 1, 2, 0, 0, 0, 0, 0));
        tbl.push_back(vec(1, 0, 1, 2, 0, 0, 1, 1, 0));
        foreach (tbl[i]) begin
            apply(tbl[i]);
            @(negedge clk); model_expect();
            n_checks++;
            if (obs_ctl() !== e_ctl) begin
                n_fail++; $display("FAIL halt ctl[%0d]: got %b want %b", i, obs_ctl(), e_ctl);
            end
            n_checks++;
            if (obs_cnt() !== e_cnt) begin
                n_fail++; $display("FAIL halt cnt[%0d]: got %h want %h", i, obs_cnt(), e_cnt);
            end
            n_checks++;
            if (halted !== (i >= 4)) begin
                n_fail++; $display("FAIL halt timing[%0d]: halted %b want %b", i, halted, i >= 4);
            end
            if (i >= 4) begin
                n_checks++;
                if (obs_ctl() !== 10'b00000_000_01) begin
                    n_fail++; $display("FAIL halt idle[%0d]: got %b", i, obs_ctl());
                end
            end
            model_advance(); @(posedge clk); #1;
        end
    endtask

    task automatic test_freeze_reset();
        logic [25:0] tbl[$];
        apply('0);
        arst_n = 1'b0;
        model_reset();
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk); #1;
        tbl.push_back(vec(1, 0, 1, 2, 0, 0, 0, 0, 0));
        tbl.push_back(vec(1, 63, 1, 2, 0, 0, 0, 0, 0));
        tbl.push_back(vec(1, 0, 1, 2, 0, 0, 0, 0, 0));
        repeat (4) tbl.push_back(vec(0, 0, 1, 2, 0, 0, 0, 0, 0));
        tbl.push_back(vec(1, 0, 1, 2, 0, 0, 0, 0, 0));
        foreach (tbl[i]) begin
            apply(tbl[i]);
            @(negedge clk); model_expect();
            n_checks++;
            if (obs_ctl() !== e_ctl) begin
                n_fail++; $display("FAIL freeze ctl[%0d]: got %b want %b", i, obs_ctl(), e_ctl);
            end
            n_checks++;
            if (obs_cnt() !== e_cnt) begin
                n_fail++; $display("FAIL freeze cnt[%0d]: got %h want %h", i, obs_cnt(), e_cnt);
            end
            model_advance(); @(posedge clk); #1;
        end
        // One drain cycle remains because the count held while frozen.
        apply(vec(1, 0, 1, 2, 0, 0, 0, 0, 0));
        #2;
        n_checks++;
        if ({running, halted, idex_flush} !== 3'b101) begin
            n_fail++; $display("FAIL freeze drain: got %b want 101", {running, halted, idex_flush});
        end
        arst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (obs_ctl() !== 10'b0 || obs_cnt() !== 96'b0) begin
            n_fail++; $display("FAIL async reset: ctl %b cnt %h want 0", obs_ctl(), obs_cnt());
        end
        @(negedge clk);
        arst_n = 1'b1;
        apply(vec(0, 0, 1, 2, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (obs_ctl() !== 10'b0 || obs_cnt() !== 96'b0) begin
            n_fail++; $display("FAIL reset idle: ctl %b cnt %h want 0", obs_ctl(), obs_cnt());
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_load_use();
        test_branch();
        test_simultaneous();
        test_random();
        test_halt();
        test_freeze_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
